// File: rtl/fetch_unit.sv
// Instruction fetch unit with a return-address stack.
// It presents the next fetch address combinationally to a synchronous program memory.
module fetch_unit #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned INS_W        = 24,
  parameter int unsigned RAS_DEPTH    = 4,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             flush,
  input  logic                             jmp_en,
  input  logic                             call_en,
  input  logic                             ret_en,
  input  logic [ADDR_W-1:0]                jmp_loc,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [INS_W-1:0]                 mem_data,
  output logic [ADDR_W-1:0]                cur_addr,
  output logic [INS_W-1:0]                 ins,
  output logic                             ins_valid,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] stack [RAS_DEPTH];
  logic [CNT_W-1:0]  count;
  logic              valid;
  logic              overflow;
  logic              underflow;

  logic              ret_hit;
  logic              ret_empty;
  logic              do_call;
  logic              do_jmp;
  logic              stack_full;
  logic [ADDR_W-1:0] push_addr;

  // A ret_en with an empty stack blocks call_en/jmp_en and falls through to stall/increment.
  assign ret_hit    = ret_en && (count != {CNT_W{1'b0}});
  assign ret_empty  = ret_en && (count == {CNT_W{1'b0}});
  assign do_call    = call_en && !ret_en;
  assign do_jmp     = jmp_en && !ret_en && !call_en;
  assign stack_full = (count == CNT_W'(RAS_DEPTH));
  assign push_addr  = fetch_pc + ADDR_W'(1);

  // Next-fetch address selection.
  always_comb begin
    mem_addr = fetch_pc + ADDR_W'(1);
    if (reset) begin
      mem_addr = ADDR_W'(RESET_VECTOR);
    end else if (ret_hit) begin
      mem_addr = stack[0];
    end else if (do_call || do_jmp) begin
      mem_addr = jmp_loc;
    end else if (stall) begin
      mem_addr = fetch_pc;
    end else begin
      mem_addr = fetch_pc + ADDR_W'(1);
    end
  end

  // Fetch pointer, validity, return stack (entry 0 is the top) and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= ADDR_W'(RESET_VECTOR);
      valid     <= 1'b0;
      count     <= {CNT_W{1'b0}};
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        stack[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      fetch_pc <= mem_addr;
      valid    <= !flush;
      if (ret_hit) begin
        for (int i = 0; i < int'(RAS_DEPTH) - 1; i++) begin
          stack[i] <= stack[i+1];
        end
        stack[RAS_DEPTH-1] <= {ADDR_W{1'b0}};
        count <= count - CNT_W'(1);
      end else if (do_call) begin
        // Shifting down discards the oldest entry when the stack is full.
        for (int i = int'(RAS_DEPTH) - 1; i > 0; i--) begin
          stack[i] <= stack[i-1];
        end
        stack[0] <= push_addr;
        if (stack_full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end else if (ret_empty) begin
        underflow <= 1'b1;
      end else begin
        count <= count;
      end
    end
  end

  assign cur_addr      = fetch_pc;
  assign ins           = valid ? mem_data : {INS_W{1'b0}};
  assign ins_valid     = valid;
  assign ras_count     = count;
  assign ras_overflow  = overflow;
  assign ras_underflow = underflow;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, jmp_en, call_en, ret_en;
  logic [7:0]  jmp_loc;
  logic [7:0]  mem_addr;
  logic [23:0] mem_data;
  logic [7:0]  cur_addr;
  logic [23:0] ins;
  logic        ins_valid;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [7:0] m_pc;
  logic [7:0] m_ras [$];
  logic       m_valid, m_ovf, m_unf;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .jmp_en(jmp_en),
    .call_en(call_en), .ret_en(ret_en), .jmp_loc(jmp_loc), .mem_addr(mem_addr),
    .mem_data(mem_data), .cur_addr(cur_addr), .ins(ins), .ins_valid(ins_valid),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  // synchronous program memory, word[a] = {16'h0, a}
  always @(posedge clk) mem_data <= {16'h0, mem_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("cur_addr", {24'h0, cur_addr}, {24'h0, m_pc});
    check("ins_valid", {31'h0, ins_valid}, {31'h0, m_valid});
    check("ins", {8'h0, ins}, m_valid ? {16'h0, m_pc} : 32'h0);
    check("ras_count", {29'h0, ras_count}, m_ras.size());
    check("ras_overflow", {31'h0, ras_overflow}, {31'h0, m_ovf});
    check("ras_underflow", {31'h0, ras_underflow}, {31'h0, m_unf});
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    m_ras.delete();
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock: drive inputs, predict mem_addr and next state, clock, then compare.
  task automatic cycle(input logic st, input logic fl, input logic jm, input logic ca,
                       input logic re, input logic [7:0] loc);
    logic [7:0] nxt;
    logic [7:0] ret_addr;
    stall = st; flush = fl; jmp_en = jm; call_en = ca; ret_en = re; jmp_loc = loc;
    #1;
    if (re && m_ras.size() > 0) begin
      nxt = m_ras.pop_front();
    end else begin
      if (re) m_unf = 1'b1;
      if (!re && ca) begin
        ret_addr = m_pc + 8'd1;
        m_ras.push_front(ret_addr);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_back());
          m_ovf = 1'b1;
        end
        nxt = loc;
      end else if (!re && jm) begin
        nxt = loc;
      end else if (st) begin
        nxt = m_pc;
      end else begin
        nxt = m_pc + 8'd1;
      end
    end
    check("mem_addr", {24'h0, mem_addr}, {24'h0, nxt});
    m_pc = nxt;
    m_valid = !fl;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic jump(input logic [7:0] loc);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, loc);
  endtask

  // Reset asserted between edges must act immediately.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; flush = 1'b0; jmp_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
    jmp_loc = 8'h00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_mem_addr", {24'h0, mem_addr}, 32'h0);
    check_outputs();
    reset = 1'b0;
    #1;
    check_outputs();

    // idle after reset: cur_addr 01,02,03, ins=000003 at the end
    idle(3);
    check("idle_cur", {24'h0, cur_addr}, 32'h03);
    check("idle_ins", {8'h0, ins}, 32'h000003);

    // call at 05 to 40, return from 42 to 06
    idle(2);
    check("call_at", {24'h0, cur_addr}, 32'h05);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40);
    check("call_tgt", {24'h0, cur_addr}, 32'h40);
    check("call_cnt", {29'h0, ras_count}, 32'd1);
    idle(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("ret_tgt", {24'h0, cur_addr}, 32'h06);
    check("ret_cnt", {29'h0, ras_count}, 32'd0);

    // five nested calls overflow, then four returns
    jump(8'h10);
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'((i + 1) * 16));
    check("ovf_flag", {31'h0, ras_overflow}, 32'd1);
    check("ovf_cnt", {29'h0, ras_count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      check("nest_ret", {24'h0, cur_addr}, 32'(8'h51 - 8'(i * 16)));
    end

    // return with empty stack, plus competing call/jmp that must be ignored
    jump(8'h07);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC0);
    check("unf_flag", {31'h0, ras_underflow}, 32'd1);
    check("unf_next", {24'h0, cur_addr}, 32'h08);

    // stall with a jump in the 2nd cycle, then flush on wrap
    jump(8'h0A);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("stall_hold", {24'h0, cur_addr}, 32'h0A);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
    check("stall_jmp", {24'h0, cur_addr}, 32'h80);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    jump(8'hFF);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("wrap_cur", {24'h0, cur_addr}, 32'h00);
    check("flush_valid", {31'h0, ins_valid}, 32'd0);
    check("flush_ins", {8'h0, ins}, 32'h0);
    idle(1);
    check("flush_once", {31'h0, ins_valid}, 32'd1);

    // randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset();
      end else begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
